// File: rtl/perf_pkg.sv
// Shared definitions for the performance-counter access bridge:
// default geometry, FSM state type and control-register bit layout.
package perf_pkg;

  localparam int          P_NUM_CTR   = 10;
  localparam logic [31:0] P_CTR_BASE  = 32'h0000_0000;
  localparam logic [31:0] P_CTRL_ADDR = 32'h0000_000F;

  localparam int SNAP_BIT   = 0;
  localparam int FREEZE_BIT = 1;
  localparam int CNT_LSB    = 16;

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

endpackage

// File: rtl/perf_shadow_regs.sv
// Shadow copy of all counters, captured together so software
// sees one consistent set; indexed read port.
module perf_shadow_regs
  import perf_pkg::*;
#(
  parameter int NUM_CTR = P_NUM_CTR,
  parameter int IW      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_cap,
  input  logic [NUM_CTR*32-1:0] i_ctr,
  input  logic [IW-1:0]         i_idx,
  output logic [31:0]           o_data
);

  logic [31:0] r_shadow [NUM_CTR];

  // capture every counter slice on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CTR; i++)
        r_shadow[i] <= '0;
    end else if (i_cap) begin
      for (int i = 0; i < NUM_CTR; i++)
        r_shadow[i] <= i_ctr[32*i +: 32];
    end
  end

  // indexed read mux
  always_comb begin
    o_data = '0;
    for (int i = 0; i < NUM_CTR; i++)
      if (i_idx == IW'(i))
        o_data = r_shadow[i];
  end

endmodule

// File: rtl/perf_counter_bridge.sv
// MEM-stage bridge: serves counter/control reads in one cycle,
// forwards everything else to L1D. Option: PERF_CLEAR_ON_SNAPSHOT_EN.
module perf_counter_bridge
  import perf_pkg::*;
#(
  parameter int          NUM_CTR   = P_NUM_CTR,
  parameter logic [31:0] CTR_BASE  = P_CTR_BASE,
  parameter logic [31:0] CTRL_ADDR = P_CTRL_ADDR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  input  logic [31:0]           cpu_address,
  input  logic [31:0]           cpu_wdata,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_resp,
  output logic                  l1d_read,
  output logic                  l1d_write,
  output logic [31:0]           l1d_address,
  output logic [31:0]           l1d_wdata,
  input  logic [31:0]           l1d_rdata,
  input  logic                  l1d_resp,
  input  logic [NUM_CTR*32-1:0] ctr_in,
  output logic                  ctr_clear,
  output logic                  snap_valid
);

  localparam int IW = (NUM_CTR > 1) ? $clog2(NUM_CTR) : 1;

  state_t      r_state;
  logic        r_resp;
  logic [31:0] r_word;
  logic        r_freeze;
  logic [15:0] r_snap_cnt;
  logic        r_snap_valid;

  logic [31:0]   w_off;
  logic          w_hit_ctr;
  logic          w_hit_ctrl;
  logic          w_perf;
  logic          w_req;
  logic          w_cap;
  logic [IW-1:0] w_idx;
  logic [31:0]   w_live;
  logic [31:0]   w_shadow;
  logic [31:0]   w_ctrl;
  logic [31:0]   w_word;

  assign w_off      = cpu_address - CTR_BASE;
  assign w_hit_ctr  = w_off < 32'(NUM_CTR);
  assign w_hit_ctrl = cpu_address == CTRL_ADDR;
  assign w_perf     = w_hit_ctr | w_hit_ctrl;
  assign w_req      = cpu_read | cpu_write;
  assign w_idx      = w_off[IW-1:0];

  assign w_cap = (r_state == IDLE) & cpu_write
               & w_hit_ctrl & cpu_wdata[SNAP_BIT];

  perf_shadow_regs #(
    .NUM_CTR (NUM_CTR),
    .IW      (IW)
  ) u_shadow (
    .clk    (clk),
    .reset  (reset),
    .i_cap  (w_cap),
    .i_ctr  (ctr_in),
    .i_idx  (w_idx),
    .o_data (w_shadow)
  );

  // live counter selected by the request index
  always_comb begin
    w_live = '0;
    for (int i = 0; i < NUM_CTR; i++)
      if (w_idx == IW'(i))
        w_live = ctr_in[32*i +: 32];
  end

  assign w_ctrl = (32'(r_snap_cnt) << CNT_LSB)
                | (32'(r_freeze) << FREEZE_BIT);

  // response word: control status or frozen/live counter
  always_comb begin
    w_word = '0;
    unique case (1'b1)
      w_hit_ctrl: w_word = w_ctrl;
      w_hit_ctr:  w_word = r_freeze ? w_shadow : w_live;
      default:    w_word = '0;
    endcase
  end

  assign l1d_read    = w_perf ? 1'b0  : cpu_read;
  assign l1d_write   = w_perf ? 1'b0  : cpu_write;
  assign l1d_address = w_perf ? 32'h0 : cpu_address;
  assign l1d_wdata   = w_perf ? 32'h0 : cpu_wdata;

  assign cpu_resp  = (r_state == RESP) ? r_resp
                   : (w_perf ? 1'b0 : l1d_resp);
  assign cpu_rdata = (r_state == RESP) ? r_word
                   : (w_perf ? 32'h0 : l1d_rdata);

  assign snap_valid = r_snap_valid;

`ifdef PERF_CLEAR_ON_SNAPSHOT_EN
  logic r_clear;
  assign ctr_clear = r_clear;
`else
  assign ctr_clear = 1'b0;
`endif

  // access FSM with control register updates
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_resp       <= 1'b0;
      r_word       <= '0;
      r_freeze     <= 1'b0;
      r_snap_cnt   <= '0;
      r_snap_valid <= 1'b0;
`ifdef PERF_CLEAR_ON_SNAPSHOT_EN
      r_clear      <= 1'b0;
`endif
    end else begin
      r_resp <= 1'b0;
`ifdef PERF_CLEAR_ON_SNAPSHOT_EN
      r_clear <= 1'b0;
`endif
      unique case (r_state)
        IDLE: begin
          if (w_req & w_perf) begin
            r_state <= RESP;
            r_resp  <= 1'b1;
            r_word  <= w_word;
            if (cpu_write & w_hit_ctrl) begin
              r_freeze <= cpu_wdata[FREEZE_BIT];
              if (cpu_wdata[SNAP_BIT]) begin
                r_snap_cnt   <= r_snap_cnt + 16'd1;
                r_snap_valid <= 1'b1;
`ifdef PERF_CLEAR_ON_SNAPSHOT_EN
                r_clear      <= 1'b1;
`endif
              end
            end
          end
        end
        RESP: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_perf_counter_bridge.sv
// Directed bench for perf_counter_bridge.
// Hand-computed expectations, one task per scenario.
module tb_perf_counter_bridge;

  localparam int N = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_read, cpu_write;
  logic [31:0]   cpu_address, cpu_wdata, cpu_rdata;
  logic          cpu_resp;
  logic          l1d_read, l1d_write;
  logic [31:0]   l1d_address, l1d_wdata, l1d_rdata;
  logic          l1d_resp;
  logic [N*32-1:0] ctr_in;
  logic          ctr_clear, snap_valid;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef PERF_CLEAR_ON_SNAPSHOT_EN
  localparam logic CLR_EXP = 1'b1;
`else
  localparam logic CLR_EXP = 1'b0;
`endif

  perf_counter_bridge dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_read    (cpu_read),
    .cpu_write   (cpu_write),
    .cpu_address (cpu_address),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_resp    (cpu_resp),
    .l1d_read    (l1d_read),
    .l1d_write   (l1d_write),
    .l1d_address (l1d_address),
    .l1d_wdata   (l1d_wdata),
    .l1d_rdata   (l1d_rdata),
    .l1d_resp    (l1d_resp),
    .ctr_in      (ctr_in),
    .ctr_clear   (ctr_clear),
    .snap_valid  (snap_valid)
  );

  always #5 clk = ~clk;

  // results of the last perf access
  logic        p_r0, p_r1, p_r2;
  logic        p_c0, p_c1, p_c2;
  logic        p_l1;
  logic [31:0] p_rd;

  task automatic set_ctr(input int i, input logic [31:0] v);
    ctr_in[32*i +: 32] = v;
  endtask

  task automatic perf_acc(input logic wr, input logic [31:0] a,
                          input logic [31:0] d);
    @(posedge clk); #1;
    cpu_read = ~wr; cpu_write = wr;
    cpu_address = a; cpu_wdata = d;
    #3;
    p_r0 = cpu_resp; p_c0 = ctr_clear;
    p_l1 = l1d_read | l1d_write;
    @(posedge clk); #1;
    p_r1 = cpu_resp; p_c1 = ctr_clear; p_rd = cpu_rdata;
    p_l1 = p_l1 | l1d_read | l1d_write;
    cpu_read = 1'b0; cpu_write = 1'b0;
    @(posedge clk); #1;
    p_r2 = cpu_resp; p_c2 = ctr_clear;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #2;
    n_cmp++;
    if (cpu_resp !== 1'b0) begin
      n_bad++; $display("FAIL reset_resp got %b want 0", cpu_resp);
    end
    n_cmp++;
    if (snap_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_snapv got %b want 0", snap_valid);
    end
    n_cmp++;
    if (ctr_clear !== 1'b0) begin
      n_bad++; $display("FAIL reset_clr got %b want 0", ctr_clear);
    end
  endtask

  task automatic test_live_read;
    set_ctr(3, 32'h55);
    perf_acc(1'b0, 32'h3, 32'h0);
    n_cmp++;
    if ({p_r0, p_r1, p_r2} !== 3'b010) begin
      n_bad++;
      $display("FAIL live_lat got %b want 010", {p_r0, p_r1, p_r2});
    end
    n_cmp++;
    if (p_rd !== 32'h55) begin
      n_bad++; $display("FAIL live_data got %h want 00000055", p_rd);
    end
    n_cmp++;
    if (p_l1 !== 1'b0) begin
      n_bad++; $display("FAIL live_l1d got %b want 0", p_l1);
    end
  endtask

  task automatic test_snapshot;
    set_ctr(0, 32'd100);
    perf_acc(1'b1, 32'hF, 32'h3);
    n_cmp++;
    if ({p_r0, p_r1, p_r2} !== 3'b010) begin
      n_bad++;
      $display("FAIL snap_lat got %b want 010", {p_r0, p_r1, p_r2});
    end
    n_cmp++;
    if ({p_c0, p_c1, p_c2} !== {1'b0, CLR_EXP, 1'b0}) begin
      n_bad++;
      $display("FAIL snap_clr got %b want 0%b0",
               {p_c0, p_c1, p_c2}, CLR_EXP);
    end
    n_cmp++;
    if (snap_valid !== 1'b1) begin
      n_bad++; $display("FAIL snap_valid got %b want 1", snap_valid);
    end
    set_ctr(0, 32'd200);
    perf_acc(1'b0, 32'h0, 32'h0);
    n_cmp++;
    if (p_rd !== 32'd100) begin
      n_bad++; $display("FAIL frozen_rd got %0d want 100", p_rd);
    end
    perf_acc(1'b0, 32'hF, 32'h0);
    n_cmp++;
    if (p_rd !== 32'h0001_0002) begin
      n_bad++; $display("FAIL ctrl_rd got %h want 00010002", p_rd);
    end
  endtask

  task automatic test_unfreeze;
    perf_acc(1'b1, 32'hF, 32'h0);
    n_cmp++;
    if ({p_c0, p_c1, p_c2} !== 3'b000) begin
      n_bad++;
      $display("FAIL unfrz_clr got %b want 000", {p_c0, p_c1, p_c2});
    end
    perf_acc(1'b0, 32'h0, 32'h0);
    n_cmp++;
    if (p_rd !== 32'd200) begin
      n_bad++; $display("FAIL live_rd got %0d want 200", p_rd);
    end
    perf_acc(1'b0, 32'hF, 32'h0);
    n_cmp++;
    if (p_rd !== 32'h0001_0000) begin
      n_bad++; $display("FAIL ctrl_rd2 got %h want 00010000", p_rd);
    end
  endtask

  task automatic test_counter_write;
    set_ctr(2, 32'hCAFE_0002);
    perf_acc(1'b1, 32'h2, 32'h1234_5678);
    n_cmp++;
    if ({p_r0, p_r1, p_r2, p_l1} !== 4'b0100) begin
      n_bad++;
      $display("FAIL cwr_ack got %b want 0100",
               {p_r0, p_r1, p_r2, p_l1});
    end
    perf_acc(1'b0, 32'h2, 32'h0);
    n_cmp++;
    if (p_rd !== 32'hCAFE_0002) begin
      n_bad++; $display("FAIL cwr_rd got %h want cafe0002", p_rd);
    end
  endtask

  task automatic test_forward;
    @(posedge clk); #1;
    cpu_read = 1'b1; cpu_address = 32'h1000;
    l1d_rdata = 32'hDEAD_BEEF; l1d_resp = 1'b0;
    #1;
    n_cmp++;
    if ({l1d_read, l1d_write, l1d_address, cpu_resp}
        !== {1'b1, 1'b0, 32'h1000, 1'b0}) begin
      n_bad++;
      $display("FAIL fwd_req got r%b w%b a%h resp%b want r1 w0 a1000 resp0",
               l1d_read, l1d_write, l1d_address, cpu_resp);
    end
    @(posedge clk); #1;
    l1d_resp = 1'b1;
    #1;
    n_cmp++;
    if ({cpu_resp, cpu_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
      n_bad++;
      $display("FAIL fwd_resp got %b %h want 1 deadbeef",
               cpu_resp, cpu_rdata);
    end
    @(posedge clk); #1;
    cpu_read = 1'b0; cpu_write = 1'b1;
    cpu_address = 32'h0000_000A; cpu_wdata = 32'hA5A5_0001;
    l1d_resp = 1'b0;
    #1;
    n_cmp++;
    if ({l1d_write, l1d_address, l1d_wdata, cpu_resp}
        !== {1'b1, 32'hA, 32'hA5A5_0001, 1'b0}) begin
      n_bad++;
      $display("FAIL fwd_bound got w%b a%h d%h resp%b want w1 a0000000a d a5a50001 resp0",
               l1d_write, l1d_address, l1d_wdata, cpu_resp);
    end
    cpu_write = 1'b0; cpu_read = 1'b1;
    cpu_address = 32'hFFFF_FFFF;
    #1;
    n_cmp++;
    if ({l1d_read, l1d_address} !== {1'b1, 32'hFFFF_FFFF}) begin
      n_bad++;
      $display("FAIL fwd_wrap got r%b a%h want r1 affffffff",
               l1d_read, l1d_address);
    end
    cpu_address = 32'h9;
    #1;
    n_cmp++;
    if ({l1d_read, l1d_address} !== {1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL top_ctr_hit got r%b a%h want r0 a0",
               l1d_read, l1d_address);
    end
    cpu_read = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_back_to_back;
    logic [3:0] seen;
    set_ctr(5, 32'h1234);
    @(posedge clk); #1;
    cpu_read = 1'b1; cpu_address = 32'h5;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      seen[3-k] = cpu_resp;
      if (k == 0) p_rd = cpu_rdata;
    end
    cpu_read = 1'b0;
    n_cmp++;
    if (seen !== 4'b1010) begin
      n_bad++; $display("FAIL b2b_pat got %b want 1010", seen);
    end
    n_cmp++;
    if (p_rd !== 32'h1234) begin
      n_bad++; $display("FAIL b2b_data got %h want 00001234", p_rd);
    end
    @(posedge clk);
  endtask

  task automatic test_reset_in_resp;
    set_ctr(0, 32'hABCD);
    perf_acc(1'b1, 32'hF, 32'h3);
    @(posedge clk); #1;
    cpu_read = 1'b1; cpu_address = 32'hF;
    @(posedge clk); #1;
    n_cmp++;
    if (cpu_resp !== 1'b1) begin
      n_bad++; $display("FAIL rir_inresp got %b want 1", cpu_resp);
    end
    reset = 1'b1; cpu_read = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (cpu_resp !== 1'b0) begin
      n_bad++; $display("FAIL rir_resp got %b want 0", cpu_resp);
    end
    reset = 1'b0;
    n_cmp++;
    if (snap_valid !== 1'b0) begin
      n_bad++; $display("FAIL rir_snapv got %b want 0", snap_valid);
    end
    perf_acc(1'b0, 32'hF, 32'h0);
    n_cmp++;
    if (p_rd !== 32'h0) begin
      n_bad++; $display("FAIL rir_ctrl got %h want 00000000", p_rd);
    end
    perf_acc(1'b1, 32'hF, 32'h2);
    perf_acc(1'b0, 32'h0, 32'h0);
    n_cmp++;
    if (p_rd !== 32'h0) begin
      n_bad++; $display("FAIL rir_shadow got %h want 00000000", p_rd);
    end
    perf_acc(1'b1, 32'hF, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    cpu_read = 1'b0; cpu_write = 1'b0;
    cpu_address = '0; cpu_wdata = '0;
    l1d_rdata = '0; l1d_resp = 1'b0;
    ctr_in = '0;
    test_reset;
    test_live_read;
    test_snapshot;
    test_unfreeze;
    test_counter_write;
    test_forward;
    test_back_to_back;
    test_reset_in_resp;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
